// File: rtl/tft_spi_arbiter_pkg.sv
// tft_pkg: arbiter state type, byte width default and requester indices
package tft_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_DRAIN = 2'd2} arb_state_t;
  localparam int TFT_DATA_W = 8;
  localparam int REQ_INIT = 0;
  localparam int REQ_SCENE = 1;
  localparam int REQ_PLAYER = 2;
  localparam int REQ_SCORE = 3;
  function automatic int wrap_inc(int v, int n);
    return (v + 1) % n;
  endfunction
endpackage

// File: rtl/tft_spi_arbiter_if.sv
// tft_spi_arbiter_if: requester bundle plus the byte link to tft_spi
interface tft_spi_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = tft_pkg::TFT_DATA_W
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ*DATA_W-1:0] tx_data;
  logic [NUM_REQ-1:0] tx_dc;
  logic [NUM_REQ-1:0] tx_transmit;
  logic spi_busy;
  logic [DATA_W-1:0] spi_data;
  logic spi_dc;
  logic spi_transmit;
  modport master (
    input req, tx_data, tx_dc, tx_transmit, spi_busy,
    output gnt, spi_data, spi_dc, spi_transmit
  );
  modport slave (
    output req, tx_data, tx_dc, tx_transmit, spi_busy,
    input gnt, spi_data, spi_dc, spi_transmit
  );
endinterface

// File: rtl/tft_spi_arbiter_rr_picker.sv
// rr_picker: first set request at or above the pointer, wrapping to index 0
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [IW-1:0]      o_idx
);
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_valid = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/tft_spi_arbiter.sv
// tft_spi_arbiter: round-robin burst arbiter in front of the shared tft_spi transmitter
module tft_spi_arbiter
  import tft_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = TFT_DATA_W,
  parameter int TIMEOUT = 65535,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  tft_spi_arbiter_if.master   bus,
  output logic [IW-1:0]       o_owner,
  output logic [15:0]         o_bytes_sent,
  output logic                o_timeout_err
);
  arb_state_t r_state, w_state_d;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IW-1:0] r_ptr, r_owner, w_win;
  logic [15:0] r_bytes;
  logic [WW-1:0] r_wd;
  logic r_terr, w_valid, w_on, w_acc, w_rel, w_to;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req(bus.req), .i_ptr(r_ptr), .o_valid(w_valid), .o_idx(w_win)
  );
  // bus outputs follow the registered owner and stay quiet whenever nobody holds grant
  assign w_on = |r_gnt;
  assign bus.gnt = r_gnt;
  assign bus.spi_data = w_on ? bus.tx_data[r_owner*DATA_W +: DATA_W] : '0;
  assign bus.spi_dc = w_on & bus.tx_dc[r_owner];
  assign bus.spi_transmit = w_on & bus.tx_transmit[r_owner];
  assign w_acc = bus.spi_transmit & ~bus.spi_busy;
  assign w_rel = ~bus.req[r_owner];
  assign w_to = (TIMEOUT != 0) && (r_wd == WW'(TIMEOUT));
  assign o_owner = r_owner;
  assign o_bytes_sent = r_bytes;
  assign o_timeout_err = r_terr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_d;
  always_comb
    w_state_d = r_state == S_IDLE  ? (w_valid ? S_GRANT : S_IDLE) :
                r_state == S_GRANT ? (w_rel || w_to ? S_DRAIN : S_GRANT) :
                r_state == S_DRAIN ? (bus.spi_busy ? S_DRAIN : S_IDLE) : S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
      r_owner <= '0;
      r_bytes <= '0;
      r_wd <= '0;
      r_terr <= 1'b0;
    end else if (r_state == S_IDLE && w_valid) begin
      r_gnt <= NUM_REQ'(1) << w_win;
      r_owner <= w_win;
      r_bytes <= '0;
      r_wd <= '0;
    end else if (r_state == S_GRANT) begin
      // a byte presented in the release cycle still counts
      r_bytes <= r_bytes + 16'(w_acc);
      r_wd <= w_acc ? '0 : r_wd + WW'(~&r_wd);
      if (w_rel || w_to) begin
        r_gnt <= '0;
        r_ptr <= IW'(wrap_inc(int'(r_owner), NUM_REQ));
      end
      if (w_to) r_terr <= 1'b1;
    end
  end
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
endmodule

// File: doc/tft_spi_arbiter.md
Name: tft_spi_arbiter

Overview:
- Shares the single tft_spi byte transmitter between NUM_REQ drawing requesters (init, scene, player, score overlay).
- Grants whole bursts, not single bytes. An owner keeps the bus until it drops its request.
- After release, the in-flight byte is drained before the next grant.
- Replaces the static enable-based muxing in the top level. Adds round-robin fairness, a stall watchdog and a byte count for debug.

Parameters:
NUM_REQ, 4, number of requesters; index 0 has reset priority (first grant after reset)
DATA_W, 8, SPI byte width
TIMEOUT, 65535, max cycles an owner may hold grant without an accepted byte; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  burst request, one bit per requester, level-held for the whole burst
gnt  out  NUM_REQ  one-hot grant, registered
tx_data  in  NUM_REQ*DATA_W  packed per-requester byte; slice i = bits [i*DATA_W +: DATA_W]
tx_dc  in  NUM_REQ  per-requester data/command flag
tx_transmit  in  NUM_REQ  per-requester transmit strobe
spi_busy  in  1  busy from tft_spi
spi_data  out  DATA_W  to tft_spi data
spi_dc  out  1  to tft_spi dc
spi_transmit  out  1  to tft_spi transmit
owner  out  $clog2(NUM_REQ)  index of current/last owner
bytes_sent  out  16  bytes accepted in current burst; wraps at 65535->0
timeout_err  out  1  sticky; set when the watchdog revokes a grant

Behaviour:
- Reset (rst low, asynchronous):
  - gnt=0, state IDLE, rr pointer=0, owner=0, bytes_sent=0, timeout_err=0, watchdog=0.
  - spi_data/spi_dc/spi_transmit are forced to 0 while gnt==0.
- States: IDLE, GRANT, DRAIN. Encode in 2 bits.
- IDLE:
  - If req!=0, pick the winner: first set bit scanning upward from the rr pointer, wrapping at NUM_REQ-1 -> 0.
  - Next edge: gnt[winner]=1, owner=winner, bytes_sent=0, watchdog=0, state GRANT.
  - Latency from req rising (sampled at edge n) to gnt high is 1 edge (visible after edge n).
- GRANT:
  - spi_data/spi_dc/spi_transmit = owner's slices, combinational from registered owner, gated by gnt.
  - A byte is accepted when spi_transmit & ~spi_busy. On acceptance: bytes_sent+1, watchdog cleared; otherwise watchdog+1.
  - If req[owner]==0 at an edge: gnt=0, rr pointer=owner+1 (mod NUM_REQ), state DRAIN.
  - If TIMEOUT!=0 and watchdog reaches TIMEOUT: same as release, plus timeout_err=1.
  - Release takes precedence over a same-cycle accepted byte only for the state change. That byte is still counted, because it was presented on the bus that cycle.
- DRAIN:
  - Outputs gated to 0.
  - Stays while spi_busy==1; when spi_busy==0, goes to IDLE at the next edge.
  - Minimum 1 cycle in DRAIN, then 1 cycle in IDLE, so two owners are always separated by at least 2 cycles of gnt==0.
- Grant handling:
  - Requests arriving during GRANT/DRAIN wait; they are never lost as long as the requester holds req.
  - A requester dropping req before being granted is simply skipped.
  - The same requester may win again only if no other req bit is set (round-robin).
- owner and bytes_sent hold their last values through DRAIN/IDLE until the next grant.
- Widths: watchdog counter is $clog2(TIMEOUT+1) bits and saturates; bytes_sent wraps.
- gnt is always one-hot or zero; a multi-hot gnt is a bug and must be covered by an assertion.

Decomposition:
- Shared package tft_pkg:
  - arbiter state enum (IDLE/GRANT/DRAIN)
  - DATA_W default
  - requester index constants REQ_INIT=0, REQ_SCENE=1, REQ_PLAYER=2, REQ_SCORE=3
- One natural sub-module: rr_picker, a combinational find-first-set from pointer with wrap. Inputs are req and the pointer; outputs are a valid flag and the winner index.

Test Plan:
- Reset then req=4'b0001 at cycle 5 -> gnt=0001 after the next edge; owner=0; tx slice 0 (0x2A, dc=0) appears on spi_data/spi_dc.
- req=4'b0110 held, each owner sends 3 bytes then drops req:
  - first gnt=0010, then gnt=0100;
  - bytes_sent=3 at each release;
  - at least 2 cycles with gnt==0 between the grants.
- Owner drops req while spi_busy=1 for 10 more cycles -> state stays DRAIN 10 cycles; no new gnt until 1 edge after busy falls.
- TIMEOUT=20, owner 2 holds req with no transmits -> gnt revoked at watchdog==20; timeout_err=1 and stays 1; next requester granted.
- rst pulled low mid-burst (bytes_sent=5) -> gnt=0, spi_transmit=0 immediately; after release, first grant goes to requester 0 if it requests.
- All four req held continuously with 1-byte bursts -> grant order 0,1,2,3,0; no requester starved.
